lcd_tx_scheduler: RTL and testbench

//  Schedules every byte sent to the Nokia LCD SPI byte serializer.

---
 rtl/lcd_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_lcd_tx_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_tx_scheduler.sv
// rtl/lcd_tx_scheduler.sv - replays the LCD init list, then arbitrates command/data bytes and tracks the cursor
module lcd_tx_scheduler #(
  parameter int INIT_LEN = 6,
  parameter int COLS     = 84,
  parameter int ROWS     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ack,
  input  logic       dat_req,
  input  logic [7:0] dat_byte,
  output logic       dat_ack,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       tx_dc,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       init_done,
  output logic [6:0] col,
  output logic [2:0] row,
  output logic       frame_end
);

  localparam int IW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef enum logic [1:0] {INIT_ISSUE, INIT_WAIT, IDLE, WAIT} state_t;

  state_t        state;
  logic [IW-1:0] idx;

  function automatic logic [7:0] init_rom(input logic [IW-1:0] i);
    case (i)
      IW'(0):  init_rom = 8'h21;
      IW'(1):  init_rom = 8'hB0;
      IW'(2):  init_rom = 8'h04;
      IW'(3):  init_rom = 8'h14;
      IW'(4):  init_rom = 8'h20;
      IW'(5):  init_rom = 8'h0C;
      default: init_rom = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_ISSUE;
      idx       <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= 8'h00;
      tx_dc     <= 1'b0;
      cmd_ack   <= 1'b0;
      dat_ack   <= 1'b0;
      init_done <= 1'b0;
      col       <= 7'd0;
      row       <= 3'd0;
      frame_end <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      cmd_ack   <= 1'b0;
      dat_ack   <= 1'b0;
      frame_end <= 1'b0;
      case (state)
        INIT_ISSUE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte  <= init_rom(idx);
            tx_dc    <= 1'b0;
            state    <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (tx_done) begin
            idx <= idx + 1'b1;
            if (idx == IW'(INIT_LEN - 1)) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= INIT_ISSUE;
            end
          end
        end
        IDLE: begin
          // Command requester has fixed priority over the data requester.
          if (!tx_busy && cmd_req) begin
            tx_start <= 1'b1;
            tx_byte  <= cmd_byte;
            tx_dc    <= 1'b0;
            cmd_ack  <= 1'b1;
            state    <= WAIT;
          end else if (!tx_busy && dat_req) begin
            tx_start <= 1'b1;
            tx_byte  <= dat_byte;
            tx_dc    <= 1'b1;
            dat_ack  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
            if (tx_dc) begin
              if (col == 7'(COLS - 1)) begin
                col <= 7'd0;
                if (row == 3'(ROWS - 1)) begin
                  row       <= 3'd0;
                  frame_end <= 1'b1;
                end else begin
                  row <= row + 3'd1;
                end
              end else begin
                col <= col + 7'd1;
              end
            end else begin
              // Set-X (1xxxxxxx) and set-Y (01000yyy) commands move the cursor when in range.
              if (tx_byte[7] && (tx_byte[6:0] < 7'(COLS)))
                col <= tx_byte[6:0];
              if ((tx_byte[7:3] == 5'b01000) && (tx_byte[2:0] < 3'(ROWS)))
                row <= tx_byte[2:0];
            end
          end
        end
        default: state <= INIT_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_tx_scheduler.sv
// tb/tb_lcd_tx_scheduler.sv - scoreboard bench for lcd_tx_scheduler with serializer and cursor reference model
module tb_lcd_tx_scheduler;

  localparam int COLS = 84;
  localparam int ROWS = 6;

  logic       clk;
  logic       reset;
  logic       cmd_req;
  logic [7:0] cmd_byte;
  logic       cmd_ack;
  logic       dat_req;
  logic [7:0] dat_byte;
  logic       dat_ack;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       tx_busy;
  logic       tx_done;
  logic       init_done;
  logic [6:0] col;
  logic [2:0] row;
  logic       frame_end;

  logic ser_busy, ser_done, stall_busy, spur_done;
  assign tx_busy = ser_busy | stall_busy;
  assign tx_done = ser_done | spur_done;

  lcd_tx_scheduler #(.INIT_LEN(6), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset),
    .cmd_req(cmd_req), .cmd_byte(cmd_byte), .cmd_ack(cmd_ack),
    .dat_req(dat_req), .dat_byte(dat_byte), .dat_ack(dat_ack),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_dc(tx_dc),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .init_done(init_done), .col(col), .row(row), .frame_end(frame_end)
  );

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         kind;   // 0 init, 1 command, 2 data
    int         ecol;
    int         erow;
    bit         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cyc = 0;
  int         starts = 0;
  int         frames = 0;
  int         m_col = 0, m_row = 0, m_frames = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_dc = 1'b0;
  bit         fast = 0;
  int         cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Reference model: cursor as a linear position within the 84x6 frame.
  function automatic void push_exp(input logic [7:0] b, input int kind, input bit gap);
    exp_t e;
    int   ib, pos;
    ib = int'(b);
    e.b = b; e.dc = (kind == 2); e.kind = kind;
    e.ecol = m_col; e.erow = m_row; e.gap = gap;
    exp_q.push_back(e);
    if (kind == 2) begin
      pos = m_row * COLS + m_col + 1;
      if (pos == COLS * ROWS) begin
        pos = 0;
        m_frames++;
      end
      m_col = pos % COLS;
      m_row = pos / COLS;
    end else if (kind == 1) begin
      if (ib >= 128 && (ib - 128) < COLS) m_col = ib - 128;
      if (ib / 8 == 8 && ib % 8 < ROWS) m_row = ib % 8;
    end
  endfunction

  // Serializer model: busy from tx_start, tx_done pulse after the chosen length.
  initial begin
    ser_busy = 0;
    ser_done = 0;
    forever begin
      @(negedge clk);
      ser_done = 0;
      if (reset) begin
        ser_busy = 0;
        cnt = 0;
      end else if (ser_busy) begin
        cnt--;
        if (cnt == 0) begin
          ser_busy = 0;
          ser_done = 1;
          done_cyc = cyc;
        end
      end else if (tx_start) begin
        ser_busy = 1;
        cnt = fast ? $urandom_range(1, 4) : 16;
      end
    end
  end

  // Monitor: pops one expectation per tx_start; otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_end) frames++;
        if (tx_start) begin
          starts++;
          if (exp_q.size() == 0) begin
            chk("unexpected_start", {24'h0, tx_byte}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_byte, e.b);
            chk("tx_dc", tx_dc, e.dc);
            chk("cmd_ack", cmd_ack, e.kind == 1);
            chk("dat_ack", dat_ack, e.kind == 2);
            chk("init_done_at_start", init_done, e.kind != 0);
            chk("col_at_start", col, e.ecol);
            chk("row_at_start", row, e.erow);
            if (e.gap) chk("done_to_start_gap", cyc - done_cyc, 2);
          end
          last_byte = tx_byte;
          last_dc   = tx_dc;
        end else begin
          chk("tx_hold", {tx_byte, tx_dc, cmd_ack, dat_ack}, {last_byte, last_dc, 2'b00});
        end
      end
    end
  end

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1; cmd_req = 0; dat_req = 0; stall_busy = 0; spur_done = 0;
    #1;
    chk("rst_tx", {tx_start, tx_byte, tx_dc}, 0);
    chk("rst_ack", {cmd_ack, dat_ack}, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_cursor", {col, row}, 0);
    chk("rst_frame_end", frame_end, 0);
    exp_q.delete();
    m_col = 0; m_row = 0; last_byte = 8'h00; last_dc = 0; starts = 0;
    push_exp(8'h21, 0, 0); push_exp(8'hB0, 0, 1); push_exp(8'h04, 0, 1);
    push_exp(8'h14, 0, 1); push_exp(8'h20, 0, 1); push_exp(8'h0C, 0, 1);
    repeat (hold) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("first_init_start", {tx_start, tx_byte}, {1'b1, 8'h21});
  endtask

  task automatic issue(input bit hc, input logic [7:0] cb, input bit hd, input logic [7:0] db,
                       input bit gap);
    int n;
    if (hc) push_exp(cb, 1, 0);
    if (hd) push_exp(db, 2, gap);
    cmd_req = hc; cmd_byte = cb; dat_req = hd; dat_byte = db;
    n = 0;
    while ((cmd_req || dat_req) && n < 3000) begin
      @(negedge clk);
      n++;
      if (cmd_ack) cmd_req = 0;
      if (dat_ack) dat_req = 0;
    end
    chk("req_timeout", {cmd_req, dat_req}, 0);
    cmd_req = 0; dat_req = 0;
  endtask

  task automatic wait_idle();
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 3 && n < 5000) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !ser_busy && !tx_done && !tx_start) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", quiet, 3);
  endtask

  initial begin
    int         s0, f0;
    logic [7:0] b;
    reset = 1; cmd_req = 0; cmd_byte = 0; dat_req = 0; dat_byte = 0;
    stall_busy = 0; spur_done = 0;

    // Reset mid-init: abort during the third init byte, then restart from 0x21.
    do_reset(2);
    s0 = 0;
    while (starts < 3 && s0 < 1000) begin @(negedge clk); s0++; end
    chk("third_start_seen", starts, 3);
    repeat (5) @(negedge clk);
    do_reset(3);

    // Full init at 16-cycle serializer; a data request raised early stays pending.
    issue(0, 8'h00, 1, 8'h55, 1);
    wait_idle();
    chk("init_done_high", init_done, 1);
    chk("cursor_after_init", col * 8 + row, m_col * 8 + m_row);

    fast = 1;
    // Simultaneous command and data requests: command wins.
    issue(1, 8'h80, 1, 8'hAA, 0);
    wait_idle();
    chk("t2_col", col, 1);

    // Cursor commands.
    issue(1, 8'h85, 0, 8'h00, 0); wait_idle(); chk("t4_col_set", col, 5);
    issue(1, 8'hD5, 0, 8'h00, 0); wait_idle(); chk("t4_col_oob", col, 5);
    issue(1, 8'h43, 0, 8'h00, 0); wait_idle(); chk("t4_row_set", row, 3);
    issue(1, 8'h46, 0, 8'h00, 0); wait_idle(); chk("t4_row_oob", row, 3);
    issue(1, 8'h0C, 0, 8'h00, 0); wait_idle(); chk("t4_other", {col, row}, {7'd5, 3'd3});

    // tx_done while idle must be ignored.
    s0 = starts;
    spur_done = 1; @(negedge clk); spur_done = 0;
    repeat (3) @(negedge clk);
    chk("spur_cursor", col * 8 + row, m_col * 8 + m_row);
    chk("spur_no_start", starts - s0, 0);

    // Stall: serializer busy for 40 cycles with a pending data request.
    s0 = starts;
    b = 8'($urandom);
    push_exp(b, 2, 0);
    stall_busy = 1; dat_byte = b; dat_req = 1;
    repeat (40) @(negedge clk);
    chk("stall_no_start", starts - s0, 0);
    stall_busy = 0;
    @(negedge clk);
    chk("stall_release", {tx_start, dat_ack}, 2'b11);
    dat_req = 0;
    wait_idle();

    // Full frame of data from the origin.
    issue(1, 8'h80, 0, 8'h00, 0);
    issue(1, 8'h40, 0, 8'h00, 0);
    wait_idle();
    f0 = frames;
    for (int i = 0; i < COLS * ROWS; i++) issue(0, 8'h00, 1, 8'($urandom), 0);
    wait_idle();
    chk("t3_frame_end_once", frames - f0, 1);
    chk("t3_cursor_origin", {col, row}, 0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 8'($urandom);
        1:       b = 8'h80 | 8'($urandom_range(0, 127));
        2:       b = 8'h40 | 8'($urandom_range(0, 7));
        default: b = 8'h0C;
      endcase
      case ($urandom_range(0, 2))
        0:       issue(1, b, 0, 8'h00, 0);
        1:       issue(0, 8'h00, 1, 8'($urandom), 0);
        default: issue(1, b, 1, 8'($urandom), 0);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    wait_idle();
    chk("final_cursor", col * 8 + row, m_col * 8 + m_row);
    chk("final_frames", frames, m_frames);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
